// File: rtl/mmio_pkg.sv
// Shared types and constants for the MMIO bridge: FSM state codes, default peripheral
// map and the value returned on error. Optional timeout: MMIO_BRIDGE_TIMEOUT_EN.
package mmio_pkg;

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StAccess = 2'd1;
  localparam state_t StResp   = 2'd2;

  localparam int unsigned DefNSlv = 6;
  localparam int unsigned DefAw   = 32;

  // Channel 0 sits in the least significant AW bits.
  localparam logic [DefNSlv*DefAw-1:0] DEF_SLV_BASE = {
    32'hFFFF_F078, 32'hFFFF_F020, 32'hFFFF_F070,
    32'hFFFF_F060, 32'hFFFF_F000, 32'h0000_0000
  };

  localparam logic [DefNSlv*DefAw-1:0] DEF_SLV_MASK = {
    32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFFC,
    32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_0000
  };

  localparam logic [31:0] ERR_RDATA = 32'h0000_0000;

endpackage

// File: rtl/mmio_addr_decode.sv
// Combinational base/mask address decoder with lowest-index priority; one-hot hit plus miss.
module mmio_addr_decode
  import mmio_pkg::*;
#(
  parameter int unsigned         N_SLV    = DefNSlv,
  parameter int unsigned         AW       = DefAw,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK
) (
  input  logic [AW-1:0]    addr,
  output logic [N_SLV-1:0] hit,
  output logic             miss
);

  // Scan from the top down so the lowest matching index overwrites any higher match.
  always_comb begin
    hit = '0;
    for (int i = N_SLV - 1; i >= 0; i--) begin
      if ((addr & SLV_MASK[i*AW +: AW]) == SLV_BASE[i*AW +: AW]) begin
        hit    = '0;
        hit[i] = 1'b1;
      end
    end
  end

  assign miss = ~|hit;

endmodule

// File: rtl/mmio_bridge_n.sv
// CPU-to-peripheral MMIO bridge: decodes one request onto N_SLV channels and waits for ready.
// Optional access timeout enabled by defining MMIO_BRIDGE_TIMEOUT_EN.
module mmio_bridge_n
  import mmio_pkg::*;
#(
  parameter int unsigned         N_SLV    = DefNSlv,
  parameter int unsigned         AW       = DefAw,
  parameter int unsigned         DW       = 32,
  parameter logic [N_SLV*AW-1:0] SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLV*AW-1:0] SLV_MASK = DEF_SLV_MASK,
  parameter int unsigned         TIMEOUT  = 16
) (
  input  logic                cpu_clk,
  input  logic                cpu_rstn,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [AW-1:0]       cpu_addr,
  input  logic [DW-1:0]       cpu_wdata,
  output logic                cpu_busy,
  output logic                cpu_ack,
  output logic                cpu_err,
  output logic [DW-1:0]       cpu_rdata,
  output logic [N_SLV-1:0]    slv_sel,
  output logic                slv_we,
  output logic [AW-1:0]       slv_addr,
  output logic [DW-1:0]       slv_wdata,
  input  logic [N_SLV*DW-1:0] slv_rdata,
  input  logic [N_SLV-1:0]    slv_ready
);

  localparam logic [DW-1:0] ErrData = DW'(ERR_RDATA);

  state_t            state_q, state_d;
  logic [N_SLV-1:0]  sel_q, sel_d;
  logic              we_q, we_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic [DW-1:0]     wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [DW-1:0]     rdata_q, rdata_d;

  logic [N_SLV-1:0]  hit;
  logic              miss;
  logic              sel_ready;
  logic [DW-1:0]     rdata_mux;

`ifdef MMIO_BRIDGE_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  // Saturating increment so a stale count can never wrap back below TIMEOUT.
  assign cnt_inc = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + 1'b1;
`endif

  mmio_addr_decode #(
    .N_SLV    (N_SLV),
    .AW       (AW),
    .SLV_BASE (SLV_BASE),
    .SLV_MASK (SLV_MASK)
  ) u_decode (
    .addr (cpu_addr),
    .hit  (hit),
    .miss (miss)
  );

  // Only the selected channel may complete the access.
  assign sel_ready = |(slv_ready & sel_q);

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < N_SLV; i++) begin
      if (sel_q[i]) rdata_mux = slv_rdata[i*DW +: DW];
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    ack_d   = 1'b0;
    err_d   = err_q;
    rdata_d = rdata_q;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
    cnt_d   = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (cpu_req) begin
          addr_d  = cpu_addr;
          we_d    = cpu_we;
          wdata_d = cpu_wdata;
          if (miss) begin
            state_d = StResp;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = ErrData;
          end else begin
            state_d = StAccess;
            sel_d   = hit;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
            cnt_d   = '0;
`endif
          end
        end
      end
      StAccess: begin
        if (sel_ready) begin
          state_d = StResp;
          ack_d   = 1'b1;
          err_d   = 1'b0;
          rdata_d = we_q ? ErrData : rdata_mux;
          sel_d   = '0;
          we_d    = 1'b0;
        end
`ifdef MMIO_BRIDGE_TIMEOUT_EN
        else begin
          cnt_d = cnt_inc;
          if (cnt_inc == CW'(TIMEOUT)) begin
            state_d = StResp;
            ack_d   = 1'b1;
            err_d   = 1'b1;
            rdata_d = ErrData;
            sel_d   = '0;
            we_d    = 1'b0;
          end
        end
`endif
      end
      StResp: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      state_q <= StIdle;
      sel_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
`ifdef MMIO_BRIDGE_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
    end
  end

  assign cpu_busy  = (state_q != StIdle);
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = rdata_q;
  assign slv_sel   = sel_q;
  assign slv_we    = we_q;
  assign slv_addr  = addr_q;
  assign slv_wdata = wdata_q;

endmodule

// File: tb/tb_mmio_bridge_n.sv
// Self-checking bench for mmio_bridge_n: directed vector table, random traffic against a
// decode/latency reference model, and hand sequences for reset abort and access timeout.
module tb_mmio_bridge_n;

  localparam int N  = 6;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            cpu_clk = 1'b0;
  logic            cpu_rstn = 1'b0;
  logic            cpu_req = 1'b0;
  logic            cpu_we = 1'b0;
  logic [AW-1:0]   cpu_addr = '0;
  logic [DW-1:0]   cpu_wdata = '0;
  logic            cpu_busy, cpu_ack, cpu_err;
  logic [DW-1:0]   cpu_rdata;
  logic [N-1:0]    slv_sel;
  logic            slv_we;
  logic [AW-1:0]   slv_addr;
  logic [DW-1:0]   slv_wdata;
  logic [N*DW-1:0] slv_rdata = '0;
  logic [N-1:0]    slv_ready = '0;

  always #5 cpu_clk = ~cpu_clk;

  mmio_bridge_n #(
    .N_SLV   (N),
    .AW      (AW),
    .DW      (DW),
    .TIMEOUT (TO)
  ) dut (
    .cpu_clk   (cpu_clk),
    .cpu_rstn  (cpu_rstn),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_busy  (cpu_busy),
    .cpu_ack   (cpu_ack),
    .cpu_err   (cpu_err),
    .cpu_rdata (cpu_rdata),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_ready (slv_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] base_tab [N] = '{32'h0000_0000, 32'hFFFF_F000, 32'hFFFF_F060,
                                32'hFFFF_F070, 32'hFFFF_F020, 32'hFFFF_F078};
  logic [31:0] mask_tab [N] = '{32'hFFFF_0000, 32'hFFFF_FFFC, 32'hFFFF_FFFC,
                                32'hFFFF_FFFC, 32'hFFFF_FFF0, 32'hFFFF_FFFC};

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          w;
    logic [31:0] data;
    logic [5:0]  exp_sel;
    logic        exp_err;
    logic [31:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge cpu_clk);
    #1;
  endtask

  // Reference decode: first table entry whose masked address equals its base.
  function automatic int ref_idx(input logic [31:0] a);
    for (int i = 0; i < N; i++) begin
      if ((a & mask_tab[i]) == base_tab[i]) return i;
    end
    return -1;
  endfunction

  // One CPU transaction with a slave that answers w cycles after it is selected.
  task automatic run_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input int w, input logic [31:0] data, input bit poke,
                         output logic [N-1:0] sel_seen, output int lat,
                         output logic err, output logic [31:0] rdata);
    logic [N-1:0] first_sel;
    logic [31:0]  held_rdata;
    int n;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    step();
    cpu_req = 1'b0; cpu_we = ~we; cpu_addr = $urandom; cpu_wdata = $urandom;
    first_sel = slv_sel;
    sel_seen  = slv_sel;
    n = 1;
    while (!cpu_ack && n < 100) begin
      chk("busy_in_access", cpu_busy, 1);
      chk("sel_held", slv_sel, first_sel);
      chk("addr_held", slv_addr, addr);
      chk("wdata_held", slv_wdata, wdata);
      chk("we_held", slv_we, we);
      cpu_req = poke && (n == 1);
      for (int i = 0; i < N; i++) slv_rdata[i*DW +: DW] = $urandom;
      slv_ready = N'($urandom) & ~slv_sel;
      for (int i = 0; i < N; i++) begin
        if (slv_sel[i]) begin
          slv_rdata[i*DW +: DW] = data;
          slv_ready[i] = (n - 1 >= w);
        end
      end
      step();
      n++;
      sel_seen |= slv_sel;
    end
    cpu_req = 1'b0;
    slv_ready = '0;
    chk("ack_seen", cpu_ack, 1);
    lat = n;
    err = cpu_err;
    rdata = cpu_rdata;
    held_rdata = cpu_rdata;
    chk("sel_clear_at_ack", slv_sel, 0);
    chk("busy_at_ack", cpu_busy, 1);
    step();
    chk("ack_one_cycle", cpu_ack, 0);
    chk("err_clears", cpu_err, 0);
    chk("idle_after_ack", cpu_busy, 0);
    chk("rdata_holds", cpu_rdata, held_rdata);
  endtask

  initial begin
    logic [N-1:0] sel;
    int           lat;
    logic         err;
    logic [31:0]  rd;
    logic [31:0]  a;
    logic         we;
    int           w, idx, k;
    logic [31:0]  d;
    bit           poke;

    vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,          0, 32'h1234_5678, 6'b000001, 1'b0, 32'h1234_5678, 2};
    vecs[1] = '{1'b0, 32'hFFFF_F063, 32'h0,          1, 32'hCAFE_0003, 6'b000100, 1'b0, 32'hCAFE_0003, 3};
    vecs[2] = '{1'b0, 32'h8000_0000, 32'h0,          0, 32'h1111_1111, 6'b000000, 1'b1, 32'h0,         1};
    vecs[3] = '{1'b0, 32'hFFFF_F02C, 32'h0,          2, 32'h0BAD_F00D, 6'b010000, 1'b0, 32'h0BAD_F00D, 4};
    vecs[4] = '{1'b1, 32'hFFFF_F000, 32'hA5A5_0001,  3, 32'hDEAD_BEEF, 6'b000010, 1'b0, 32'h0,         5};
    vecs[5] = '{1'b0, 32'hFFFF_F07B, 32'h0,          0, 32'h7777_0005, 6'b100000, 1'b0, 32'h7777_0005, 2};
    vecs[6] = '{1'b0, 32'hFFFF_F072, 32'h0,          0, 32'h3333_0003, 6'b001000, 1'b0, 32'h3333_0003, 2};
    vecs[7] = '{1'b1, 32'hFFFF_F004, 32'h0000_1111,  0, 32'h2222_2222, 6'b000000, 1'b1, 32'h0,         1};
    vecs[8] = '{1'b0, 32'h0000_FFFC, 32'h0,          1, 32'h5555_AAAA, 6'b000001, 1'b0, 32'h5555_AAAA, 3};
    vecs[9] = '{1'b0, 32'h0001_0000, 32'h0,          0, 32'h4444_4444, 6'b000000, 1'b1, 32'h0,         1};

    // Reset state
    step();
    step();
    chk("rst_busy", cpu_busy, 0);
    chk("rst_ack", cpu_ack, 0);
    chk("rst_err", cpu_err, 0);
    chk("rst_rdata", cpu_rdata, 0);
    chk("rst_sel", slv_sel, 0);
    chk("rst_we", slv_we, 0);
    chk("rst_addr", slv_addr, 0);
    chk("rst_wdata", slv_wdata, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    step();

    // Directed vectors
    for (int v = 0; v < 10; v++) begin
      run_txn(vecs[v].we, vecs[v].addr, vecs[v].wdata, vecs[v].w, vecs[v].data, 1'b0,
              sel, lat, err, rd);
      chk($sformatf("vec%0d_sel", v), sel, vecs[v].exp_sel);
      chk($sformatf("vec%0d_lat", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_err", v), err, vecs[v].exp_err);
      chk($sformatf("vec%0d_rdata", v), rd, vecs[v].exp_rdata);
    end

    // Second request pulsed during ACCESS must be dropped
    run_txn(1'b0, 32'hFFFF_F060, 32'h0, 3, 32'h9999_0001, 1'b1, sel, lat, err, rd);
    chk("poke_sel", sel, 6'b000100);
    chk("poke_lat", lat, 5);
    chk("poke_rdata", rd, 32'h9999_0001);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("poke_no_extra_ack", cpu_ack, 0);
      chk("poke_stays_idle", cpu_busy, 0);
    end

    // Randomized traffic against the reference model
    for (int t = 0; t < 80; t++) begin
      k = $urandom_range(0, N);
      if (k == N) a = $urandom;
      else a = base_tab[k] | ($urandom & ~mask_tab[k]);
      we = 1'($urandom);
      w = $urandom_range(0, 6);
      d = $urandom;
      poke = ($urandom_range(0, 3) == 0);
      idx = ref_idx(a);
      run_txn(we, a, $urandom, w, d, poke, sel, lat, err, rd);
      chk("rnd_sel", sel, (idx < 0) ? 0 : (1 << idx));
      chk("rnd_lat", lat, (idx < 0) ? 1 : w + 2);
      chk("rnd_err", err, idx < 0);
      chk("rnd_rdata", rd, (idx < 0 || we) ? 32'h0 : d);
    end

    // Reset mid-ACCESS: immediate clear, no ack
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'hFFFF_F070; cpu_wdata = 32'h1357_9BDF;
    step();
    cpu_req = 1'b0;
    step();
    chk("abort_busy_before", cpu_busy, 1);
    chk("abort_sel_before", slv_sel, 6'b001000);
    #2;
    cpu_rstn = 1'b0;
    #1;
    chk("abort_busy", cpu_busy, 0);
    chk("abort_sel", slv_sel, 0);
    chk("abort_we", slv_we, 0);
    chk("abort_addr", slv_addr, 0);
    chk("abort_wdata", slv_wdata, 0);
    chk("abort_ack", cpu_ack, 0);
    chk("abort_err", cpu_err, 0);
    chk("abort_rdata", cpu_rdata, 0);
    step();
    chk("abort_no_ack", cpu_ack, 0);
    @(negedge cpu_clk);
    cpu_rstn = 1'b1;
    step();
    chk("abort_idle", cpu_busy, 0);
    chk("abort_no_ack2", cpu_ack, 0);
    run_txn(1'b0, 32'h0000_0010, 32'h0, 0, 32'h1234_5678, 1'b0, sel, lat, err, rd);
    chk("post_abort_sel", sel, 6'b000001);
    chk("post_abort_lat", lat, 2);
    chk("post_abort_rdata", rd, 32'h1234_5678);

`ifdef MMIO_BRIDGE_TIMEOUT_EN
    // Silent slave: TIMEOUT access cycles then error
    run_txn(1'b0, 32'hFFFF_F020, 32'h0, 1000, 32'hFEED_0004, 1'b0, sel, lat, err, rd);
    chk("to_sel", sel, 6'b010000);
    chk("to_lat", lat, TO + 1);
    chk("to_err", err, 1);
    chk("to_rdata", rd, 0);
    // Ready on the very cycle the counter expires wins
    run_txn(1'b0, 32'hFFFF_F020, 32'h0, TO - 1, 32'hFEED_0005, 1'b0, sel, lat, err, rd);
    chk("to_tie_lat", lat, TO + 1);
    chk("to_tie_err", err, 0);
    chk("to_tie_rdata", rd, 32'hFEED_0005);
`else
    // Without timeout a slow slave is waited on well past TIMEOUT cycles
    run_txn(1'b0, 32'hFFFF_F020, 32'h0, 30, 32'hFEED_0006, 1'b0, sel, lat, err, rd);
    chk("slow_sel", sel, 6'b010000);
    chk("slow_lat", lat, 32);
    chk("slow_err", err, 0);
    chk("slow_rdata", rd, 32'hFEED_0006);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mmio_bridge_n.md
Name: mmio_bridge_n

Overview:
Parametrised successor to the SoC's peripheral bridge. Decodes one CPU memory-mapped request onto N_SLV slave channels through a base/mask table, and runs a registered request/ready handshake so slow slaves can insert wait states. It returns registered read data, ack and error to the CPU, and sits between myCPU and DRAM/timer/LED/switch/digit peripherals.

Parameters:
N_SLV, 6, number of slave channels (1..16)
AW, 32, address width
DW, 32, data width
SLV_BASE, {0x0000_0000,0xFFFF_F000,0xFFFF_F060,0xFFFF_F070,0xFFFF_F020,0xFFFF_F078}, packed N_SLV*AW base table, index 0 first
SLV_MASK, {0xFFFF_0000,0xFFFF_FFFC,0xFFFF_FFFC,0xFFFF_FFFC,0xFFFF_FFF0,0xFFFF_FFFC}, packed N_SLV*AW mask table
TIMEOUT, 16, ACCESS cycles without ready before error (>=1)

Ports:
cpu_clk  in  1  system clock
cpu_rstn  in  1  asynchronous reset, active-low
cpu_req  in  1  request strobe; sampled in IDLE only
cpu_we  in  1  1=write, 0=read
cpu_addr  in  AW  byte address
cpu_wdata  in  DW  write data
cpu_busy  out  1  high whenever state != IDLE
cpu_ack  out  1  one-cycle completion pulse
cpu_err  out  1  valid with cpu_ack; decode miss or timeout
cpu_rdata  out  DW  read data, valid with cpu_ack
slv_sel  out  N_SLV  one-hot slave select
slv_we  out  1  write enable to selected slave
slv_addr  out  AW  registered address
slv_wdata  out  DW  registered write data
slv_rdata  in  N_SLV*DW  per-slave read data, channel i at [i*DW +: DW]
slv_ready  in  N_SLV  per-slave completion

Behaviour:
- Reset (async, cpu_rstn=0): state IDLE; cpu_busy, cpu_ack, cpu_err, slv_sel, slv_we = 0; cpu_rdata, slv_addr, slv_wdata = 0; timeout counter = 0.
- Decode: hit[i] = ((cpu_addr & MASK[i]) == BASE[i]). Lowest index wins on overlap. Miss = no hit.
- FSM states are IDLE, ACCESS, RESP.
- IDLE: on cpu_req, capture addr, we and wdata into slv_addr, slv_we and slv_wdata. On hit, latch one-hot slv_sel and go to ACCESS. On miss, go to RESP with err=1 and rdata=0.
- ACCESS: slv_sel, slv_we, slv_addr and slv_wdata are held stable. When slv_ready[sel]=1, capture slv_rdata[sel] into cpu_rdata (reads; writes load 0), clear slv_sel and slv_we, and go to RESP with err=0. Ready from unselected channels is ignored.
- RESP: cpu_ack=1 for exactly one cycle with cpu_err and cpu_rdata valid, then IDLE. cpu_rdata holds its value until the next ack. cpu_err clears the cycle after.
- Latency: req at T, ready at T+1 -> ack at T+2 (minimum 2 cycles). Miss: ack at T+1.
- cpu_req while busy is ignored; no queueing. The CPU must wait for ack.
- A slave seeing slv_ready high in the same cycle it is first selected is legal (zero-wait).
- A reset asserted mid-ACCESS aborts the access immediately. No ack is issued and outputs go to reset values.
- Counter width is $clog2(TIMEOUT+1). It saturates and does not wrap.

Optional Feature:
MMIO_BRIDGE_TIMEOUT_EN
- Defined: the counter clears on entry to ACCESS and increments each ACCESS cycle without ready. When it reaches TIMEOUT, go to RESP with err=1, rdata=0, slv_sel cleared. If ready and timeout coincide, ready wins (err=0).
- Undefined: there is no counter and ACCESS waits indefinitely for ready. cpu_err is raised only on decode miss.

Decomposition:
- Package mmio_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - default BASE/MASK constants for the standard peripheral map
  - localparam for the error read value (0)
- Sub-module mmio_addr_decode: combinational base/mask match plus priority encoder. Outputs are one-hot hit and miss.
- The FSM, capture registers and timeout counter live in mmio_bridge_n.

Test Plan:
- Read of 0x0000_0010, slave0 ready on first ACCESS cycle with rdata 0x1234_5678 -> slv_sel=6'b000001, cpu_ack at T+2, cpu_rdata=0x1234_5678, cpu_err=0.
- Write 0xA5A5_0001 to 0xFFFF_F000, slave1 ready after 3 wait cycles -> slv_we=1 and slv_wdata held for 4 cycles, ack at T+5, err=0.
- Access to 0x8000_0000 (miss) -> slv_sel never asserted, ack at T+1, err=1, rdata=0.
- With MMIO_BRIDGE_TIMEOUT_EN and TIMEOUT=16, read to 0xFFFF_F020 with slave4 never ready -> 16 ACCESS cycles, then ack with err=1, rdata=0, slv_sel cleared.
- Second cpu_req pulsed during ACCESS -> ignored; exactly one ack; slv_addr unchanged.
- cpu_rstn pulsed low mid-ACCESS -> all outputs 0 asynchronously, no ack; a following req completes normally.
